// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between the core data port (M0) and a secondary master (M1).
// Optional feature macro ARB_TIMEOUT_EN adds a bus_ready watchdog that completes stuck transactions with ERR_RDATA.
module periph_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [63:0] ERR_RDATA      = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter int          ST_W           = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     m0_addr,
  input  logic [63:0]     m0_wdata,
  input  logic [ST_W-1:0] m0_store_type,
  input  logic            m0_valid,
  output logic            m0_ready,
  output logic [63:0]     m0_rdata,
  input  logic [63:0]     m1_addr,
  input  logic [63:0]     m1_wdata,
  input  logic [ST_W-1:0] m1_store_type,
  input  logic            m1_valid,
  output logic            m1_ready,
  output logic [63:0]     m1_rdata,
  output logic [63:0]     bus_addr,
  output logic [63:0]     bus_wdata,
  output logic [ST_W-1:0] bus_store_type,
  output logic            bus_valid,
  input  logic            bus_ready,
  input  logic [63:0]     bus_rdata,
  output logic [1:0]      grant,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DRAIN} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   drain_owner, drain_owner_nxt;
  logic   pick0, pick1;
  logic   timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // Restarts whenever a new owner or the drain phase begins, so each phase gets a full budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE || state_nxt != state) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = !bus_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      drain_owner <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      drain_owner <= drain_owner_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_store_type <= '0;
    end else if (pick0) begin
      bus_addr       <= m0_addr;
      bus_wdata      <= m0_wdata;
      bus_store_type <= m0_store_type;
    end else if (pick1) begin
      bus_addr       <= m1_addr;
      bus_wdata      <= m1_wdata;
      bus_store_type <= m1_store_type;
    end
  end

  // A master that withdraws valid loses its response; the coincident-ready case is treated the same way.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    drain_owner_nxt = drain_owner;
    pick0           = 1'b0;
    pick1           = 1'b0;
    bus_valid       = 1'b0;
    grant           = 2'b00;
    m0_ready        = 1'b0;
    m1_ready        = 1'b0;
    timeout_err     = 1'b0;
    case (state)
      IDLE: begin
        if (m0_valid && (!m1_valid || last_grant)) begin
          pick0     = 1'b1;
          state_nxt = BUSY0;
        end else if (m1_valid) begin
          pick1     = 1'b1;
          state_nxt = BUSY1;
        end
      end
      BUSY0: begin
        bus_valid = 1'b1;
        grant     = 2'b01;
        if (bus_ready || timeout_hit) begin
          m0_ready       = m0_valid;
          timeout_err    = timeout_hit;
          last_grant_nxt = 1'b0;
          state_nxt      = IDLE;
        end else if (!m0_valid) begin
          drain_owner_nxt = 1'b0;
          state_nxt       = DRAIN;
        end
      end
      BUSY1: begin
        bus_valid = 1'b1;
        grant     = 2'b10;
        if (bus_ready || timeout_hit) begin
          m1_ready       = m1_valid;
          timeout_err    = timeout_hit;
          last_grant_nxt = 1'b1;
          state_nxt      = IDLE;
        end else if (!m1_valid) begin
          drain_owner_nxt = 1'b1;
          state_nxt       = DRAIN;
        end
      end
      DRAIN: begin
        bus_valid = 1'b1;
        if (bus_ready || timeout_hit) begin
          timeout_err    = timeout_hit;
          last_grant_nxt = drain_owner;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready without bus_ready can only come from the watchdog, hence the error pattern.
  assign m0_rdata = !m0_ready ? '0 : (bus_ready ? bus_rdata : ERR_RDATA);
  assign m1_rdata = !m1_ready ? '0 : (bus_ready ? bus_rdata : ERR_RDATA);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: directed transactions push expected responses,
// a monitor pops and compares them whenever a master sees ready.
module tb_periph_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m0_store_type = '0, m1_store_type = '0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [63:0] m0_rdata, m1_rdata;
  logic [63:0] bus_addr, bus_wdata;
  logic [2:0]  bus_store_type;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;

  typedef struct {
    int          master;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  st;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] rsp_q[$];
  int          resp_wait = 0;
  int          checks = 0;
  int          errors = 0;

  periph_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_store_type(m0_store_type),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_store_type(m1_store_type),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_store_type(bus_store_type),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expect(input int m, input logic [63:0] a, input logic [63:0] w,
                             input logic [2:0] st, input logic [63:0] rd, input logic err);
    exp_t e;
    e.master = m; e.addr = a; e.wdata = w; e.st = st; e.rdata = rd; e.err = err;
    exp_q.push_back(e);
    rsp_q.push_back(rd);
  endtask

  task automatic applyStimulus(input int m, input logic [63:0] a, input logic [63:0] w, input logic [2:0] st);
    if (m == 0) begin
      m0_addr = a; m0_wdata = w; m0_store_type = st; m0_valid = 1'b1;
    end else begin
      m1_addr = a; m1_wdata = w; m1_store_type = st; m1_valid = 1'b1;
    end
  endtask

  task automatic release_master(input int m);
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle after the master's ready.
  task automatic wait_ready(input int m);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      seen = (m == 0) ? m0_ready : m1_ready;
    end
    if (!seen) fail_bound((m == 0) ? "m0_ready_wait" : "m1_ready_wait");
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_valid = 1'b0; m1_valid = 1'b0;
    resp_wait = 0;
    tick();
    tick();
    checkOutput("rst_bus_valid", {63'b0, bus_valid}, 64'd0);
    checkOutput("rst_grant", {62'b0, grant}, 64'd0);
    checkOutput("rst_m0_ready", {63'b0, m0_ready}, 64'd0);
    checkOutput("rst_m1_ready", {63'b0, m1_ready}, 64'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 64'd0);
    checkOutput("rst_bus_addr", bus_addr, 64'd0);
    checkOutput("rst_timeout_err", {63'b0, timeout_err}, 64'd0);
    reset = 1'b0;
  endtask

  // Peripheral model: responds on the resp_wait-th consecutive cycle of bus_valid.
  initial begin
    int busy_n = 0;
    forever begin
      @(posedge clock);
      #1;
      if (bus_valid && !reset) begin
        busy_n++;
        if (resp_wait != 0 && busy_n == resp_wait) begin
          bus_ready = 1'b1;
          bus_rdata = (rsp_q.size() != 0) ? rsp_q.pop_front() : 64'd0;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = '0;
        end
      end else begin
        busy_n    = 0;
        bus_ready = 1'b0;
        bus_rdata = '0;
      end
    end
  end

  // Monitor: scores every ready pulse and checks the mandatory idle cycle after it.
  initial begin
    bit   prev_rdy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_rdy = 1'b0;
      end else begin
        if (prev_rdy) begin
          checkOutput("idle_gap_bus_valid", {63'b0, bus_valid}, 64'd0);
          checkOutput("idle_gap_grant", {62'b0, grant}, 64'd0);
        end
        prev_rdy = m0_ready | m1_ready;
        if (m0_ready && m1_ready) fail_bound("both_ready");
        else if (m0_ready || m1_ready) begin
          if (exp_q.size() == 0) begin
            fail_bound("unexpected_ready");
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_master", {63'b0, m1_ready}, (e.master == 1) ? 64'd1 : 64'd0);
            checkOutput("sb_grant", {62'b0, grant}, (e.master == 1) ? 64'd2 : 64'd1);
            checkOutput("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
            checkOutput("sb_other_rdata", m1_ready ? m0_rdata : m1_rdata, 64'd0);
            checkOutput("sb_bus_addr", bus_addr, e.addr);
            checkOutput("sb_bus_wdata", bus_wdata, e.wdata);
            checkOutput("sb_bus_st", {61'b0, bus_store_type}, {61'b0, e.st});
            checkOutput("sb_timeout_err", {63'b0, timeout_err}, {63'b0, e.err});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Single M0 load, ready on the 3rd BUSY0 cycle
    do_reset();
    push_expect(0, 64'h2000_0010, 64'd0, 3'd0, 64'h1234, 1'b0);
    resp_wait = 3;
    applyStimulus(0, 64'h2000_0010, 64'd0, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      @(negedge clock);
      checkOutput("t1_grant", {62'b0, grant}, 64'd1);
      checkOutput("t1_m0_ready", {63'b0, m0_ready}, (c == 3) ? 64'd1 : 64'd0);
    end
    tick();
    release_master(0);
    tick();

    // Both valid from reset: M0, M1, M0, M1
    do_reset();
    resp_wait = 1;
    push_expect(0, 64'h2000_0A00, 64'd0, 3'd0, 64'hA0, 1'b0);
    push_expect(1, 64'h2000_0B00, 64'd0, 3'd0, 64'hB0, 1'b0);
    push_expect(0, 64'h2000_0C00, 64'd0, 3'd0, 64'hC0, 1'b0);
    push_expect(1, 64'h2000_0D00, 64'd0, 3'd0, 64'hD0, 1'b0);
    fork
      begin
        applyStimulus(0, 64'h2000_0A00, 64'd0, 3'd0);
        wait_ready(0);
        applyStimulus(0, 64'h2000_0C00, 64'd0, 3'd0);
        wait_ready(0);
        release_master(0);
      end
      begin
        applyStimulus(1, 64'h2000_0B00, 64'd0, 3'd0);
        wait_ready(1);
        applyStimulus(1, 64'h2000_0D00, 64'd0, 3'd0);
        wait_ready(1);
        release_master(1);
      end
    join

    // Abort: M0 drops valid in BUSY0 cycle 2, bus_ready in cycle 4; M1 then wins over a fresh M0
    resp_wait = 4;
    rsp_q.push_back(64'h0BAD);
    applyStimulus(0, 64'h2000_0040, 64'd0, 3'd0);
    tick();
    tick();
    release_master(0);
    push_expect(1, 64'h2000_0050, 64'h11, 3'd1, 64'h5050, 1'b0);
    push_expect(0, 64'h2000_0060, 64'd0, 3'd0, 64'h6060, 1'b0);
    applyStimulus(1, 64'h2000_0050, 64'h11, 3'd1);
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) applyStimulus(0, 64'h2000_0060, 64'd0, 3'd0);
      @(negedge clock);
      checkOutput("t4_bus_valid", {63'b0, bus_valid}, 64'd1);
      checkOutput("t4_bus_addr", bus_addr, 64'h2000_0040);
      checkOutput("t4_m0_ready", {63'b0, m0_ready}, 64'd0);
      checkOutput("t4_m1_ready", {63'b0, m1_ready}, 64'd0);
      tick();
    end
    fork
      begin wait_ready(1); release_master(1); end
      begin wait_ready(0); release_master(0); end
    join

    // M1 store with M0 arriving mid-transaction; payload changes after capture are ignored
    resp_wait = 4;
    push_expect(1, 64'h2000_0100, 64'hAA, 3'd3, 64'h77, 1'b0);
    push_expect(0, 64'h2000_0020, 64'd0, 3'd0, 64'h5555, 1'b0);
    applyStimulus(1, 64'h2000_0100, 64'hAA, 3'd3);
    tick();
    tick();
    applyStimulus(0, 64'h2000_0020, 64'd0, 3'd0);
    m1_addr = 64'h3000_0000;
    m1_wdata = 64'hFF;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clock);
      checkOutput("t3_m0_ready", {63'b0, m0_ready}, 64'd0);
      checkOutput("t3_bus_addr", bus_addr, 64'h2000_0100);
      checkOutput("t3_bus_wdata", bus_wdata, 64'hAA);
      tick();
    end
    fork
      begin wait_ready(1); release_master(1); end
      begin wait_ready(0); release_master(0); end
    join

`ifdef ARB_TIMEOUT_EN
    // Peripheral never answers: watchdog completes in the 4th BUSY0 cycle
    resp_wait = 0;
    exp_q.push_back('{master: 0, addr: 64'h2000_0080, wdata: 64'd0, st: 3'd0,
                      rdata: 64'hDEAD_BEEF_DEAD_BEEF, err: 1'b1});
    applyStimulus(0, 64'h2000_0080, 64'd0, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      @(negedge clock);
      checkOutput("t5_early_timeout_err", {63'b0, timeout_err}, 64'd0);
      checkOutput("t5_early_m0_ready", {63'b0, m0_ready}, 64'd0);
    end
    wait_ready(0);
    release_master(0);
    checkOutput("t5_bus_valid_after", {63'b0, bus_valid}, 64'd0);
    tick();
`endif

    // Asynchronous reset during BUSY1 while bus_ready is high
    resp_wait = 3;
    rsp_q.push_back(64'h99);
    applyStimulus(1, 64'h2000_0200, 64'd0, 3'd0);
    tick();
    tick();
    @(negedge clock);
    checkOutput("t6_bus_valid_busy", {63'b0, bus_valid}, 64'd1);
    checkOutput("t6_grant_busy", {62'b0, grant}, 64'd2);
    tick();
    #1;
    checkOutput("t6_m1_ready_pre", {63'b0, m1_ready}, 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_bus_valid_rst", {63'b0, bus_valid}, 64'd0);
    checkOutput("t6_grant_rst", {62'b0, grant}, 64'd0);
    checkOutput("t6_m1_ready_rst", {63'b0, m1_ready}, 64'd0);
    checkOutput("t6_m1_rdata_rst", m1_rdata, 64'd0);
    release_master(1);
    tick();
    reset = 1'b0;
    tick();

    checkOutput("exp_q_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
